// File: rtl/sorter_pkg.sv
// Shared defaults, pad value and FSM encoding for the sample collector.
// Imported by the insertion half and the collector top.
package sorter_pkg;

    localparam int WIDTH_DEF = 3;
    localparam int N_DEF     = 32;

    // Empty slots hold all-ones so they always sort to the top of a half.
    localparam logic [WIDTH_DEF-1:0] PAD = '1;

    typedef enum logic [1:0] {
        FILL_A = 2'd0,
        FILL_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/sorted_insert_half.sv
// One n-entry ascending array with single-cycle stable insertion.
// Slot 0 is lowest; the top slot (always pad) falls off on insert.
module sorted_insert_half
    import sorter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int n     = N_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               insert,
    input  logic [WIDTH-1:0]   data,
    output logic [n*WIDTH-1:0] slots
);

    localparam logic [WIDTH-1:0] PAD_W = '1;

    logic [n*WIDTH-1:0] cur;
    logic [n*WIDTH-1:0] nxt;
    logic [n-1:0]       le;

    // Entries not above the new sample stay put; this makes ties stable.
    always_comb begin
        le = '0;
        for (int k = 0; k < n; k++) begin
            le[k] = (cur[k*WIDTH +: WIDTH] <= data);
        end
    end

    // Each slot above the insertion point takes its lower neighbour.
    always_comb begin
        nxt = cur;
        if (!le[0]) begin
            nxt[0 +: WIDTH] = data;
        end
        for (int k = 1; k < n; k++) begin
            if (!le[k]) begin
                nxt[k*WIDTH +: WIDTH] = le[k-1] ? data
                                      : cur[(k-1)*WIDTH +: WIDTH];
            end
        end
    end

    // Array storage: pad on reset/clear, shifted contents on insert.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cur <= {n{PAD_W}};
        end else if (insert) begin
            cur <= nxt;
        end
    end

    assign slots = cur;

endmodule

// File: rtl/sample_collector.sv
// Collects samples into two sorted halves and pulses load per half.
// Frame control FSM and the real-sample counter live here.
module sample_collector
    import sorter_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int n     = N_DEF,
    localparam int CW    = $clog2(2*n) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 flush,
    output logic [1:0]           load,
    output logic [2*n*WIDTH-1:0] inba,
    output logic [CW-1:0]        sample_cnt
);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          last_a;
    logic          last_b;
    logic          flush_a;
    logic          ins_a;
    logic          ins_b;
    logic          clear_frame;

    assign in_ready    = !rst && (state != HOLD);
    assign accept      = in_valid && in_ready;
    assign last_a      = accept && (cnt == CW'(n - 1));
    assign last_b      = accept && (cnt == CW'(2*n - 1));
    // A same-cycle sample counts, so flush with one new sample still closes.
    assign flush_a     = flush && (accept || (cnt != '0));
    assign ins_a       = accept && (state == FILL_A);
    assign ins_b       = accept && (state == FILL_B);
    assign clear_frame = (state == HOLD);

    // Frame sequencing, sample counting and registered load pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL_A;
            cnt   <= '0;
            load  <= 2'b00;
        end else begin
            load <= 2'b00;
            unique case (state)
                FILL_A: begin
                    if (accept) begin
                        cnt <= cnt + CW'(1);
                    end
                    if (last_a && !flush) begin
                        state <= FILL_B;
                        load  <= 2'b01;
                    end else if (flush_a) begin
                        state <= HOLD;
                        load  <= 2'b11;
                    end
                end
                FILL_B: begin
                    if (accept) begin
                        cnt <= cnt + CW'(1);
                    end
                    if (last_b || flush) begin
                        state <= HOLD;
                        load  <= 2'b10;
                    end
                end
                HOLD: begin
                    state <= FILL_A;
                    cnt   <= '0;
                end
                default: begin
                    state <= FILL_A;
                end
            endcase
        end
    end

    assign sample_cnt = cnt;

    sorted_insert_half #(
        .WIDTH(WIDTH),
        .n    (n)
    ) u_half_a (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_frame),
        .insert(ins_a),
        .data  (in_data),
        .slots (inba[n*WIDTH-1:0])
    );

    sorted_insert_half #(
        .WIDTH(WIDTH),
        .n    (n)
    ) u_half_b (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_frame),
        .insert(ins_b),
        .data  (in_data),
        .slots (inba[2*n*WIDTH-1:n*WIDTH])
    );

endmodule

// File: tb/tb_sample_collector.sv
// Directed bench for sample_collector with a queue-and-sort frame model.
// Model outputs are compared every negedge; literal checks pin key cases.
module tb_sample_collector;

    localparam int W  = 3;
    localparam int N  = 32;
    localparam int CW = $clog2(2*N) + 1;
    localparam int VW = 2*N*W;

    typedef logic [VW-1:0] vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          flush;
    logic [1:0]    load;
    logic [VW-1:0] inba;
    logic [CW-1:0] sample_cnt;

    int vectors = 0;
    int errors  = 0;
    bit started = 1'b0;

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int           m_cnt  = 0;
    bit           m_inb  = 1'b0;
    bit           m_hold = 1'b0;
    logic [1:0]   m_load = 2'b00;

    sample_collector #(.WIDTH(W), .n(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .load      (load),
        .inba      (inba),
        .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input vec_t act, input vec_t exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected bus: sorted queues in their halves, pad everywhere else.
    function automatic vec_t model_inba();
        vec_t v;
        v = '1;
        foreach (qa[k]) v[k*W +: W] = qa[k];
        foreach (qb[k]) v[(N+k)*W +: W] = qb[k];
        return v;
    endfunction

    // Frame model: collect per half, sort, close on full half or flush.
    always @(posedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            m_cnt = 0; m_inb = 0; m_hold = 0; m_load = 2'b00;
        end else if (m_hold) begin
            qa.delete();
            qb.delete();
            m_cnt = 0; m_inb = 0; m_hold = 0; m_load = 2'b00;
        end else begin
            m_load = 2'b00;
            if (in_valid) begin
                if (m_inb) begin
                    qb.push_back(in_data);
                    qb.sort();
                end else begin
                    qa.push_back(in_data);
                    qa.sort();
                end
                m_cnt++;
            end
            if (!m_inb) begin
                if (flush && qa.size() > 0) begin
                    m_hold = 1; m_load = 2'b11;
                end else if (qa.size() == N) begin
                    m_inb = 1; m_load = 2'b01;
                end
            end else if (flush || qb.size() == N) begin
                m_hold = 1; m_load = 2'b10;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("ready", vec_t'(in_ready), vec_t'(!rst && !m_hold));
            if (!rst) begin
                chk("load", vec_t'(load), vec_t'(m_load));
                chk("inba", vec_t'(inba), model_inba());
                if (m_load[1]) begin
                    chk("cnt", vec_t'(sample_cnt), vec_t'(m_cnt));
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] v, input logic f);
        in_valid = 1'b1; in_data = v; flush = f;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic idle(input logic f);
        in_valid = 1'b0; flush = f;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    vec_t exp_v;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0;
        @(posedge clk); #1;
        started = 1'b1;
        @(posedge clk); #1;
        chk("rst load", vec_t'(load), vec_t'(2'b00));
        chk("rst inba", vec_t'(inba), '1);
        chk("rst cnt", vec_t'(sample_cnt), '0);
        chk("rst ready", vec_t'(in_ready), '0);
        rst = 1'b0;
        #1;
        chk("ready after rst", vec_t'(in_ready), vec_t'(1));

        // Case 1: 64 threes back-to-back
        for (int i = 1; i <= 64; i++) begin
            send(3'd3, 1'b0);
            if (i == 32) chk("c1 loadA", vec_t'(load), vec_t'(2'b01));
        end
        chk("c1 loadB", vec_t'(load), vec_t'(2'b10));
        chk("c1 cnt", vec_t'(sample_cnt), vec_t'(64));
        chk("c1 inba", vec_t'(inba), {(2*N){3'd3}});
        chk("c1 hold ready", vec_t'(in_ready), '0);
        idle(1'b0);
        chk("c1 ready back", vec_t'(in_ready), vec_t'(1));
        chk("c1 cleared", vec_t'(inba), '1);

        // Case 2: descending runs into half A
        for (int r = 0; r < 4; r++) begin
            for (int v = 7; v >= 0; v--) send(W'(v), 1'b0);
        end
        chk("c2 loadA", vec_t'(load), vec_t'(2'b01));
        exp_v = '1;
        for (int k = 0; k < N; k++) exp_v[k*W +: W] = W'(k / 4);
        chk("c2 halfA", vec_t'(inba), exp_v);
        idle(1'b1);
        chk("c2 flushB load", vec_t'(load), vec_t'(2'b10));
        chk("c2 cnt", vec_t'(sample_cnt), vec_t'(32));
        idle(1'b0);

        // Case 3: short frame then flush
        send(3'd5, 1'b0);
        send(3'd2, 1'b0);
        send(3'd2, 1'b0);
        send(3'd0, 1'b0);
        idle(1'b1);
        chk("c3 load", vec_t'(load), vec_t'(2'b11));
        exp_v = '1;
        exp_v[11:0] = {3'd5, 3'd2, 3'd2, 3'd0};
        chk("c3 inba", vec_t'(inba), exp_v);
        chk("c3 cnt", vec_t'(sample_cnt), vec_t'(4));
        idle(1'b0);

        // Case 4: flush together with sample 40
        for (int i = 1; i <= 40; i++) send(W'(i % 8), i == 40);
        chk("c4 load", vec_t'(load), vec_t'(2'b10));
        chk("c4 cnt", vec_t'(sample_cnt), vec_t'(40));
        idle(1'b0);

        // Case 5: reset mid-frame, then a fresh random frame
        for (int i = 0; i < 45; i++) send(W'((i * 5) % 8), 1'b0);
        rst = 1'b1;
        idle(1'b0);
        idle(1'b0);
        chk("c5 rst load", vec_t'(load), '0);
        chk("c5 rst inba", vec_t'(inba), '1);
        chk("c5 rst cnt", vec_t'(sample_cnt), '0);
        rst = 1'b0;
        #1;
        chk("c5 ready", vec_t'(in_ready), vec_t'(1));
        for (int i = 1; i <= 64; i++) begin
            send(W'($urandom_range(0, 7)), 1'b0);
            if (i == 1) chk("c5 no stale", vec_t'(load), '0);
            if (i == 32) chk("c5 loadA", vec_t'(load), vec_t'(2'b01));
        end
        chk("c5 loadB", vec_t'(load), vec_t'(2'b10));
        chk("c5 cnt", vec_t'(sample_cnt), vec_t'(64));
        idle(1'b0);

        // Case 6: ignored flushes (empty frame, HOLD)
        idle(1'b1);
        chk("c6 empty load", vec_t'(load), '0);
        chk("c6 empty ready", vec_t'(in_ready), vec_t'(1));
        send(3'd4, 1'b1);
        chk("c6 one load", vec_t'(load), vec_t'(2'b11));
        chk("c6 one cnt", vec_t'(sample_cnt), vec_t'(1));
        idle(1'b1);
        chk("c6 hold load", vec_t'(load), '0);
        chk("c6 hold ready", vec_t'(in_ready), vec_t'(1));
        chk("c6 hold cnt", vec_t'(sample_cnt), '0);
        idle(1'b0);
        chk("c6 quiet", vec_t'(load), '0);
        idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/sample_collector.md
SAMPLE_COLLECTOR -- requirements
Module: sample_collector

Interface
REQ-001 Parameter WIDTH, default 3, bit width of one sample.
REQ-002 Parameter n, default 32, entries per half-frame; a frame holds 2*n samples.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  in_data carries a sample.
REQ-006 in_ready  output  1  block accepts a sample this cycle; transfer occurs when in_valid && in_ready.
REQ-007 in_data  input  WIDTH  sample value, unsigned.
REQ-008 flush  input  1  close the current frame early and pad the unfilled slots.
REQ-009 load  output  2  load[0] = half A complete, load[1] = half B complete; each is a one-cycle pulse to the downstream register.
REQ-010 inba  output  2*n*WIDTH  slot k occupies bits [(k+1)*WIDTH-1 : k*WIDTH]; half A is slots 0..n-1, half B is slots n..2n-1.
REQ-011 sample_cnt  output  clog2(2n)+1  count of real samples in the frame; valid while load[1]=1.

Function
REQ-012 Each half SHALL be held ascending at all times: slot 0 lowest, pad value PAD = all-ones.
REQ-013 An accepted sample SHALL be inserted into the active half in one cycle. Every entry greater than the sample shifts up one slot. Ties are stable: the new sample lands after existing equal entries. The top entry, always PAD, is discarded.
REQ-014 The FSM SHALL have three states: FILL_A, FILL_B and HOLD. The reset state is FILL_A.
REQ-015 FILL_A: accepted samples insert into half A. The n-th accepted sample moves the FSM to FILL_B, and load SHALL equal 2'b01 on the next cycle.
REQ-016 FILL_B: accepted samples insert into half B. The n-th accepted sample moves the FSM to HOLD.
REQ-017 HOLD: lasts exactly one cycle, with in_ready=0 and load[1]=1.
REQ-018 On leaving HOLD, both halves SHALL reset to all-PAD, the counter SHALL clear, and the FSM SHALL enter FILL_A.
REQ-019 inba SHALL be stable and sorted during every cycle in which load[0] or load[1] is high.
REQ-020 Half A SHALL remain unchanged from its load[0] pulse through HOLD.
REQ-021 in_ready SHALL be 1 in FILL_A and FILL_B and 0 in HOLD. in_ready SHALL be 0 while rst is high.
REQ-022 Flush in FILL_A with at least one sample in the frame SHALL go to HOLD, with load=2'b11 on the next cycle.
REQ-023 Flush in FILL_B SHALL go to HOLD, with load=2'b10 on the next cycle.
REQ-024 Flush in FILL_A with zero samples in the frame, and flush in HOLD, SHALL be ignored.
REQ-025 If in_valid and flush occur in the same cycle, the sample SHALL be accepted first and the frame closes including it.
REQ-026 If flush coincides with the n-th sample of half A, the frame SHALL close as in REQ-022, with load=2'b11.
REQ-027 sample_cnt SHALL count accepted samples from 0 to 2n, saturating the frame at 2n.
REQ-028 Throughput: one full frame SHALL take 2n+1 cycles when in_valid is held high.

Reset
REQ-029 While rst=1 at a clock edge: state=FILL_A, every slot of inba=PAD, load=2'b00, sample_cnt=0, in_ready=0.
REQ-030 The first cycle after rst deasserts SHALL have in_ready=1.
REQ-031 Reset mid-frame SHALL discard all partial data. No load pulse SHALL follow the reset.

Structure
REQ-032 A shared package sorter_pkg SHALL hold the WIDTH and n defaults, the PAD constant, and the FSM state encoding.
REQ-033 One sub-module, sorted_insert_half, SHALL implement the n-entry insertion array of REQ-013 with a clear input and an insert-enable input. It SHALL be instantiated twice.
REQ-034 The FSM and the counter SHALL live in sample_collector. No combinational path SHALL run from in_data to load.

Verification (WIDTH=3, n=32)
REQ-035 Case 1: after reset, send 64 samples of value 3 back-to-back. Expect load=01 on the cycle after sample 32, load=10 on the cycle after sample 64, sample_cnt=64, every slot=3, and in_ready=0 for one cycle.
REQ-036 Case 2: send half A as 7,6,...,0 repeated four times. Expect half A at load[0] to be 0,0,0,0,1,1,1,1,...,7,7,7,7.
REQ-037 Case 3: send samples 5,2,2,0 then flush. Expect load=11 on the next cycle, half A = 0,2,2,5 followed by 28 slots of 7, half B all 7, and sample_cnt=4.
REQ-038 Case 4: send 40 samples with flush asserted together with sample 40. Expect load=10 on the next cycle and sample_cnt=40.
REQ-039 Case 5: assert rst after sample 45, then send a fresh 64-sample frame. Expect no stale load pulse, and the new frame's output to match its own input sorted per half.
REQ-040 Case 6: assert flush at frame start with no samples sent, and flush during HOLD. Expect no state change and no extra load pulse.
